output_packer: RTL and testbench

- Downstream of the PE array.
- Captures one vector of N_DIM_ARRAY signed activations from the array's output bus and packs it into MEM_DATA_WIDTH memory words, lane 0 first.
- Writes the words to the activation memory over a valid/ready handshake, with an auto-incrementing word address.
- Lets the array start its next computation as soon as the capture is taken.

---
 rtl/output_packer_if.sv | 24 ++
 rtl/output_packer.sv | 138 +++++++++++++
 tb/tb_output_packer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/output_packer_if.sv
// Memory write port of output_packer: valid/ready request carrying a word address and packed data.
interface output_packer_if #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned MEM_DATA_WIDTH = 32
);
    logic                      mem_wr_valid;
    logic                      mem_wr_ready;
    logic [ADDR_WIDTH-1:0]     mem_wr_addr;
    logic [MEM_DATA_WIDTH-1:0] mem_wr_data;

    modport master (
        output mem_wr_valid,
        output mem_wr_addr,
        output mem_wr_data,
        input  mem_wr_ready
    );

    modport slave (
        input  mem_wr_valid,
        input  mem_wr_addr,
        input  mem_wr_data,
        output mem_wr_ready
    );
endinterface

// File: rtl/output_packer.sv
// Captures one PE-array result vector and writes it out as packed memory words, lane 0 first.
// Optional ReLU clamp at capture time: define OUTPUT_PACKER_RELU_EN to add the relu_en port.
module output_packer #(
    parameter int unsigned N_DIM_ARRAY    = 8,
    parameter int unsigned ACT_DATA_WIDTH = 8,
    parameter int unsigned MEM_DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH     = 16,
    localparam int unsigned EPW           = MEM_DATA_WIDTH / ACT_DATA_WIDTH,
    localparam int unsigned NV_W          = $clog2(N_DIM_ARRAY + 1)
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           clear,
    input  logic                                           set_base,
    input  logic [ADDR_WIDTH-1:0]                          base_addr,
    input  logic                                           capture_valid,
    output logic                                           capture_ready,
    input  logic [NV_W-1:0]                                num_valid,
    // Lanes are two's-complement; only the sign bit is ever inspected.
    input  logic [N_DIM_ARRAY-1:0][ACT_DATA_WIDTH-1:0]     output_array,
`ifdef OUTPUT_PACKER_RELU_EN
    input  logic                                           relu_en,
`endif
    output_packer_if.master                                mem,
    output logic                                           done,
    output logic [ADDR_WIDTH-1:0]                          words_written
);

    localparam int unsigned NW_MAX = (N_DIM_ARRAY + EPW - 1) / EPW;
    localparam int unsigned KW     = (NW_MAX > 1) ? $clog2(NW_MAX) : 1;

    typedef enum logic [0:0] {StIdle, StDrain} state_e;

    state_e                                  state_q;
    logic [NW_MAX-1:0][MEM_DATA_WIDTH-1:0]   vec_q, vec_d;
    logic [KW-1:0]                           k_q, last_k_q, last_k_d;
    logic [ADDR_WIDTH-1:0]                   addr_q, words_q;
    logic                                    valid_q;
    logic [MEM_DATA_WIDTH-1:0]               word_data;
    logic [ACT_DATA_WIDTH-1:0]               lane_val;
    int                                      nv_eff;
    logic                                    abort, accept, last_accept, capture, relu;

`ifdef OUTPUT_PACKER_RELU_EN
    assign relu = relu_en;
`else
    assign relu = 1'b0;
`endif

    // Abort gates acceptance so an abandoned write never counts or pulses done.
    assign abort         = reset | clear;
    assign accept        = valid_q & mem.mem_wr_ready & ~abort;
    assign last_accept   = accept & (k_q == last_k_q);
    assign capture_ready = (state_q == StIdle) | last_accept;
    assign capture       = capture_valid & capture_ready & ~abort;
    assign done          = last_accept;

    assign mem.mem_wr_valid = valid_q;
    assign mem.mem_wr_addr  = addr_q;
    assign mem.mem_wr_data  = word_data;
    assign words_written    = words_q;

    // Zero-fill unused lanes at capture so draining is a plain word select.
    always_comb begin
        vec_d    = '0;
        lane_val = '0;
        if (num_valid == '0 || num_valid > NV_W'(N_DIM_ARRAY)) begin
            nv_eff = int'(N_DIM_ARRAY);
        end else begin
            nv_eff = int'(32'(num_valid));
        end
        for (int l = 0; l < int'(N_DIM_ARRAY); l++) begin
            lane_val = output_array[l];
            if (relu && lane_val[ACT_DATA_WIDTH-1]) begin
                lane_val = '0;
            end
            if (l < nv_eff) begin
                vec_d[l / int'(EPW)][(l % int'(EPW)) * int'(ACT_DATA_WIDTH) +: ACT_DATA_WIDTH] =
                    lane_val;
            end
        end
        last_k_d = KW'((nv_eff + int'(EPW) - 1) / int'(EPW) - 1);
    end

    always_comb begin
        word_data = '0;
        for (int w = 0; w < int'(NW_MAX); w++) begin
            if (k_q == KW'(w)) begin
                word_data = vec_q[w];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (abort) begin
            state_q  <= StIdle;
            vec_q    <= '0;
            k_q      <= '0;
            last_k_q <= '0;
            addr_q   <= '0;
            words_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (set_base) begin
                        addr_q <= base_addr;
                    end
                    if (capture) begin
                        vec_q    <= vec_d;
                        k_q      <= '0;
                        last_k_q <= last_k_d;
                        valid_q  <= 1'b1;
                        state_q  <= StDrain;
                    end
                end
                StDrain: begin
                    if (accept) begin
                        addr_q  <= addr_q + ADDR_WIDTH'(1);
                        words_q <= words_q + ADDR_WIDTH'(1);
                        k_q     <= k_q + KW'(1);
                    end
                    // A capture here can only happen alongside the last acceptance.
                    if (capture) begin
                        vec_q    <= vec_d;
                        k_q      <= '0;
                        last_k_q <= last_k_d;
                    end else if (last_accept) begin
                        valid_q <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_output_packer.sv
// Directed bench for output_packer: a queue of expected writes derived from lane/packing rules,
// checked against the memory port every cycle, plus literal spot checks.
module tb_output_packer;

    logic            clk = 1'b0;
    logic            reset, clear, set_base, capture_valid, capture_ready, done;
    logic [15:0]     base_addr, words_written;
    logic [3:0]      num_valid;
    logic [7:0][7:0] output_array;
`ifdef OUTPUT_PACKER_RELU_EN
    logic            relu_en;
`endif

    output_packer_if #(.ADDR_WIDTH(16), .MEM_DATA_WIDTH(32)) mem_bus ();

    output_packer dut (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear),
        .set_base      (set_base),
        .base_addr     (base_addr),
        .capture_valid (capture_valid),
        .capture_ready (capture_ready),
        .num_valid     (num_valid),
        .output_array  (output_array),
`ifdef OUTPUT_PACKER_RELU_EN
        .relu_en       (relu_en),
`endif
        .mem           (mem_bus.master),
        .done          (done),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
        bit          last;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] model_next_addr = '0;
    logic [15:0] exp_words = '0;
    int          done_cnt = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0][7:0] seq_lanes(input logic [7:0] start);
        logic [7:0][7:0] v;
        for (int i = 0; i < 8; i++) v[i] = start + 8'(i);
        return v;
    endfunction

    // Expected words: 4 lanes per word, lane 0 in the low byte, lanes past nv read as zero.
    task automatic model_push(input logic [7:0][7:0] lanes, input int nv, input bit relu);
        int          nvv, nw;
        logic [31:0] word;
        logic [7:0]  v;
        nvv = (nv == 0) ? 8 : nv;
        nw  = (nvv + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            word = '0;
            for (int e = 0; e < 4; e++) begin
                if (w * 4 + e < nvv) begin
                    v = lanes[w * 4 + e];
                    if (relu && v[7]) v = 8'h00;
                    word[8 * e +: 8] = v;
                end
            end
            exp_q.push_back('{addr: model_next_addr, data: word, last: (w == nw - 1)});
            model_next_addr = model_next_addr + 16'd1;
        end
    endtask

    // Per-cycle comparison against the expected-write queue.
    always @(negedge clk) begin
        logic acc, exp_last;
        if (reset || clear) begin
            if (clear && !reset) check("done_during_clear", {31'b0, done}, 32'd0);
            exp_q.delete();
            exp_words       = '0;
            model_next_addr = '0;
        end else begin
            acc = mem_bus.mem_wr_valid && mem_bus.mem_wr_ready;
            check("wr_valid", {31'b0, mem_bus.mem_wr_valid}, {31'b0, exp_q.size() != 0});
            exp_last = 1'b0;
            if (exp_q.size() != 0) begin
                check("wr_addr", {16'b0, mem_bus.mem_wr_addr}, {16'b0, exp_q[0].addr});
                check("wr_data", mem_bus.mem_wr_data, exp_q[0].data);
                exp_last = acc && exp_q[0].last;
            end
            check("done", {31'b0, done}, {31'b0, exp_last});
            check("capture_ready", {31'b0, capture_ready}, {31'b0, (exp_q.size() == 0) || exp_last});
            check("words_written", {16'b0, words_written}, {16'b0, exp_words});
            if (done) done_cnt++;
            if (acc && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                exp_words = exp_words + 16'd1;
            end
        end
    end

    task automatic send_vec(input logic [7:0][7:0] lanes, input int nv, input bit relu,
                            input bit sb, input logic [15:0] base);
        bit got = 1'b0;
        output_array  = lanes;
        num_valid     = 4'(nv);
        capture_valid = 1'b1;
        set_base      = sb;
        base_addr     = base;
`ifdef OUTPUT_PACKER_RELU_EN
        relu_en       = relu;
`endif
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (capture_ready) begin
                got = 1'b1;
                break;
            end
        end
        check("capture_handshake", {31'b0, got}, 32'd1);
        @(posedge clk);
        if (got) begin
            if (sb) model_next_addr = base;
`ifdef OUTPUT_PACKER_RELU_EN
            model_push(lanes, nv, relu);
`else
            model_push(lanes, nv, 1'b0);
`endif
        end
        #1;
        capture_valid = 1'b0;
        set_base      = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !mem_bus.mem_wr_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, {31'b0, ok}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int done_before;
        logic [7:0][7:0] lanes;

        reset = 1'b1; clear = 1'b0; set_base = 1'b0; base_addr = '0;
        capture_valid = 1'b0; num_valid = '0; output_array = '0;
`ifdef OUTPUT_PACKER_RELU_EN
        relu_en = 1'b0;
`endif
        mem_bus.mem_wr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_valid", {31'b0, mem_bus.mem_wr_valid}, 32'd0);
        check("rst_ready", {31'b0, capture_ready}, 32'd1);
        check("rst_addr", {16'b0, mem_bus.mem_wr_addr}, 32'd0);
        check("rst_data", mem_bus.mem_wr_data, 32'd0);
        check("rst_words", {16'b0, words_written}, 32'd0);
        @(posedge clk); #1;

        // Full vector at base 0x0100.
        send_vec(seq_lanes(8'h01), 8, 1'b0, 1'b1, 16'h0100);
        check("pin_full_w0", exp_q[0].data, 32'h04030201);
        check("pin_full_w1", exp_q[1].data, 32'h08070605);
        check("pin_full_a0", {16'b0, exp_q[0].addr}, 32'h0100);
        wait_drain("drain_full");
        check("full_words", {16'b0, words_written}, 32'd2);
        check("full_done_cnt", done_cnt, 32'd1);

        // Partial vector, nv=5.
        @(posedge clk); #1;
        send_vec(seq_lanes(8'h11), 5, 1'b0, 1'b0, 16'h0000);
        check("pin_part_w0", exp_q[0].data, 32'h14131211);
        check("pin_part_w1", exp_q[1].data, 32'h00000015);
        check("pin_part_a1", {16'b0, exp_q[1].addr}, 32'h0103);
        wait_drain("drain_partial");
        check("part_done_cnt", done_cnt, 32'd2);

        // Backpressure on word 0.
        @(posedge clk); #1;
        mem_bus.mem_wr_ready = 1'b0;
        send_vec(seq_lanes(8'h21), 8, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid", {31'b0, mem_bus.mem_wr_valid}, 32'd1);
            check("bp_addr", {16'b0, mem_bus.mem_wr_addr}, 32'h0104);
            check("bp_data", mem_bus.mem_wr_data, 32'h24232221);
        end
        @(posedge clk); #1;
        mem_bus.mem_wr_ready = 1'b1;
        wait_drain("drain_bp");
        check("bp_words", {16'b0, words_written}, 32'd6);

        // Back-to-back: second vector waits for the last-word acceptance.
        @(posedge clk); #1;
        send_vec(seq_lanes(8'h31), 8, 1'b0, 1'b0, 16'h0000);
        send_vec(seq_lanes(8'h41), 8, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        check("b2b_valid", {31'b0, mem_bus.mem_wr_valid}, 32'd1);
        check("b2b_addr", {16'b0, mem_bus.mem_wr_addr}, 32'h0108);
        check("b2b_data", mem_bus.mem_wr_data, 32'h44434241);
        wait_drain("drain_b2b");
        check("b2b_words", {16'b0, words_written}, 32'd10);

        // Clear after word 0 is accepted.
        @(posedge clk); #1;
        send_vec(seq_lanes(8'h51), 8, 1'b0, 1'b0, 16'h0000);
        done_before = done_cnt;
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        check("clr_valid", {31'b0, mem_bus.mem_wr_valid}, 32'd0);
        check("clr_words", {16'b0, words_written}, 32'd0);
        check("clr_ready", {31'b0, capture_ready}, 32'd1);
        check("clr_addr", {16'b0, mem_bus.mem_wr_addr}, 32'd0);
        check("clr_no_done", done_cnt, done_before);

        // Signed lanes {-3,5,-128,127}, nv=4; upper lanes carry junk that must be dropped.
        @(posedge clk); #1;
        lanes = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h7F, 8'h80, 8'h05, 8'hFD};
        send_vec(lanes, 4, 1'b1, 1'b0, 16'h0000);
`ifdef OUTPUT_PACKER_RELU_EN
        check("pin_relu_word", exp_q[0].data, 32'h7F000500);
`else
        check("pin_raw_word", exp_q[0].data, 32'h7F8005FD);
`endif
        check("pin_relu_addr", {16'b0, exp_q[0].addr}, 32'd0);
        wait_drain("drain_relu");
        check("relu_words", {16'b0, words_written}, 32'd1);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
